// File: rtl/tm1638_ctrl.sv
// TM1638 front-panel driver: latches digits/dots/LEDs/brightness once per frame
// and streams the three write transactions over STB/CLK/DIO.
module tm1638_ctrl #(
    parameter int CLK_DIV = 4,
    parameter int REFRESH = 50000
) (
    input  logic        clk,
    input  logic        rs,
    input  logic [31:0] digits,
    input  logic [7:0]  dots,
    input  logic [7:0]  leds,
    input  logic [2:0]  bright,
    input  logic        disp_on,
    output logic        tm_stb,
    output logic        tm_clk,
    output logic        tm_dio,
    output logic        busy,
    output logic        frame_done
);
    localparam int CW = $clog2(2 * CLK_DIV);
    localparam int RW = $clog2(REFRESH + 1);

    typedef enum logic [2:0] {IDLE, LATCH, SETUP, SEND, HOLD, GAP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          half, half_n;
    logic [2:0]    bit_idx, bit_n;
    logic [4:0]    byte_idx, byte_n;
    logic [1:0]    trans, trans_n;
    logic [RW-1:0] ref_cnt;
    logic          ref_done, last_byte, dio_ld, dio;
    logic [7:0]    sel_byte;
    logic [3:0]    addr;

    logic [31:0]   sh_digits;
    logic [7:0]    sh_dots, sh_leds;
    logic [2:0]    sh_bright;
    logic          sh_on;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'd0: seg7 = 7'h3F;
            4'd1: seg7 = 7'h06;
            4'd2: seg7 = 7'h5B;
            4'd3: seg7 = 7'h4F;
            4'd4: seg7 = 7'h66;
            4'd5: seg7 = 7'h6D;
            4'd6: seg7 = 7'h7D;
            4'd7: seg7 = 7'h07;
            4'd8: seg7 = 7'h7F;
            4'd9: seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    assign ref_done  = (ref_cnt == RW'(REFRESH - 1));
    assign last_byte = (trans == 2'd1) ? (byte_idx == 5'd16) : 1'b1;

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        half_n  = half;
        bit_n   = bit_idx;
        byte_n  = byte_idx;
        trans_n = trans;
        dio_ld  = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (ref_done) state_n = LATCH;
            end
            LATCH: begin
                cnt_n   = '0;
                state_n = SETUP;
                trans_n = 2'd0;
                byte_n  = 5'd0;
                bit_n   = 3'd0;
                half_n  = 1'b0;
                dio_ld  = 1'b1;
            end
            SETUP: if (cnt == CW'(CLK_DIV - 1)) begin
                cnt_n   = '0;
                half_n  = 1'b0;
                state_n = SEND;
            end
            SEND: if (cnt == CW'(CLK_DIV - 1)) begin
                cnt_n = '0;
                if (!half) begin
                    half_n = 1'b1;
                end else begin
                    // next bit (or next byte) is presented as tm_clk falls
                    half_n = 1'b0;
                    if (bit_idx == 3'd7) begin
                        bit_n = 3'd0;
                        if (last_byte) begin
                            state_n = HOLD;
                        end else begin
                            byte_n = byte_idx + 5'd1;
                            dio_ld = 1'b1;
                        end
                    end else begin
                        bit_n  = bit_idx + 3'd1;
                        dio_ld = 1'b1;
                    end
                end
            end
            HOLD: if (cnt == CW'(CLK_DIV - 1)) begin
                cnt_n   = '0;
                state_n = GAP;
            end
            GAP: if (cnt == CW'(2 * CLK_DIV - 1)) begin
                cnt_n = '0;
                if (trans == 2'd2) begin
                    state_n = ref_done ? LATCH : IDLE;
                end else begin
                    trans_n = trans + 2'd1;
                    byte_n  = 5'd0;
                    bit_n   = 3'd0;
                    dio_ld  = 1'b1;
                    state_n = SETUP;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Byte selected by the next-state counters, so DIO can be loaded on the same edge.
    always_comb begin
        addr = 4'(byte_n - 5'd1);
        case (trans_n)
            2'd0: sel_byte = 8'h40;
            2'd1: begin
                if (byte_n == 5'd0)
                    sel_byte = 8'hC0;
                else if (addr[0])
                    sel_byte = {7'b0, sh_leds[addr[3:1]]};
                else
                    sel_byte = {sh_dots[addr[3:1]], seg7(sh_digits[{addr[3:1], 2'b00} +: 4])};
            end
            default: sel_byte = {4'h8, sh_on, sh_bright};
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rs) begin
            state    <= IDLE;
            cnt      <= '0;
            half     <= 1'b0;
            bit_idx  <= 3'd0;
            byte_idx <= 5'd0;
            trans    <= 2'd0;
            dio      <= 1'b0;
            ref_cnt  <= RW'(REFRESH - 1);
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            half     <= half_n;
            bit_idx  <= bit_n;
            byte_idx <= byte_n;
            trans    <= trans_n;
            if (dio_ld) dio <= sel_byte[bit_n];
            if (state == LATCH)  ref_cnt <= RW'(1);
            else if (!ref_done)  ref_cnt <= ref_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rs) begin
            sh_digits <= '0;
            sh_dots   <= '0;
            sh_leds   <= '0;
            sh_bright <= '0;
            sh_on     <= 1'b0;
        end else if (state == LATCH) begin
            sh_digits <= digits;
            sh_dots   <= dots;
            sh_leds   <= leds;
            sh_bright <= bright;
            sh_on     <= disp_on;
        end
    end

    assign tm_stb     = !(state == SETUP || state == SEND || state == HOLD);
    assign tm_clk     = !(state == SEND && !half);
    assign tm_dio     = dio;
    assign busy       = (state == SETUP || state == SEND || state == HOLD || state == GAP);
    assign frame_done = (state == GAP) && (trans == 2'd2) && (cnt == CW'(2 * CLK_DIV - 1));
endmodule

// File: tb/tb_tm1638_ctrl.sv
// Directed bench for tm1638_ctrl: decodes the serial bus into bytes and compares
// whole frames, timing and reset behaviour against hand-derived values.
module tb_tm1638_ctrl;
    logic        clk = 1'b0;
    logic        rs = 1'b0;
    logic [31:0] digits = 32'h76543210;
    logic [7:0]  dots = 8'h00;
    logic [7:0]  leds = 8'h00;
    logic [2:0]  bright = 3'd7;
    logic        disp_on = 1'b1;
    logic        tm_stb, tm_clk, tm_dio, busy, frame_done;

    tm1638_ctrl #(.CLK_DIV(4), .REFRESH(2000)) dut (
        .clk(clk), .rs(rs), .digits(digits), .dots(dots), .leds(leds),
        .bright(bright), .disp_on(disp_on), .tm_stb(tm_stb), .tm_clk(tm_clk),
        .tm_dio(tm_dio), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // bus monitor, sampled on the falling system-clock edge
    logic [7:0] bus_q[$];
    int         rise_t[$];
    logic       p_stb = 1'b1, p_clk = 1'b1, p_dio = 1'b0, p_busy = 1'b0;
    logic [7:0] sh = 8'h00;
    int         bcnt = 0, cyc = 0, busy_run = 0, busy_len = 0, fd_cnt = 0, viol = 0;

    always @(negedge clk) begin
        cyc    <= cyc + 1;
        p_stb  <= tm_stb;
        p_clk  <= tm_clk;
        p_dio  <= tm_dio;
        p_busy <= busy;
        if (tm_stb && !p_stb) begin
            bcnt <= 0;
        end else if (!tm_stb && tm_clk && !p_clk) begin
            sh <= {tm_dio, sh[7:1]};
            if (bcnt == 7) begin
                bus_q.push_back({tm_dio, sh[7:1]});
                bcnt <= 0;
            end else begin
                bcnt <= bcnt + 1;
            end
        end
        if (!tm_stb && !p_stb && tm_clk && p_clk && tm_dio != p_dio) viol <= viol + 1;
        if (busy) busy_run <= busy_run + 1;
        else if (p_busy) begin
            busy_len <= busy_run;
            busy_run <= 0;
        end
        if (busy && !p_busy) rise_t.push_back(cyc);
        if (frame_done) fd_cnt <= fd_cnt + 1;
    end

    logic [7:0] exp_b[19];

    function automatic logic [7:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 8'h3F;  4'h1: return 8'h06;  4'h2: return 8'h5B;  4'h3: return 8'h4F;
            4'h4: return 8'h66;  4'h5: return 8'h6D;  4'h6: return 8'h7D;  4'h7: return 8'h07;
            4'h8: return 8'h7F;  4'h9: return 8'h6F;
            default: return 8'h00;
        endcase
    endfunction

    task automatic build_exp(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] l,
                             input logic on, input logic [2:0] br);
        exp_b[0] = 8'h40;
        exp_b[1] = 8'hC0;
        for (int i = 0; i < 8; i++) begin
            exp_b[2 + 2*i] = seg_of(d[4*i +: 4]) | (dp[i] ? 8'h80 : 8'h00);
            exp_b[3 + 2*i] = l[i] ? 8'h01 : 8'h00;
        end
        exp_b[18] = 8'h80 | (on ? 8'h08 : 8'h00) | {5'b0, br};
    endtask

    task automatic check_frame(input string tag);
        chk({tag, "_nbytes"}, bus_q.size(), 19);
        for (int i = 0; i < 19; i++)
            if (i < bus_q.size()) chk($sformatf("%s_b%0d", tag, i), {24'b0, bus_q[i]}, {24'b0, exp_b[i]});
    endtask

    task automatic wait_busy(input logic lvl, input int max, input string tag);
        int n = 0;
        while (busy !== lvl && n < max) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'b0, busy}, {31'b0, lvl});
    endtask

    initial begin
        int n, lo, hi;
        repeat (3) @(negedge clk);
        chk("rst_out", {27'b0, tm_stb, tm_clk, tm_dio, busy, frame_done}, 32'b11000);

        // frame 1: basic digits, T1 bit timing
        rs = 1'b1;
        n = 0;
        while (tm_stb && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("stb_latency", n, 2);
        lo = 0;
        while (!tm_stb && lo < 200) begin
            @(negedge clk);
            lo++;
        end
        chk("t1_stb_low", lo, 72);
        hi = 0;
        while (tm_stb && hi < 200) begin
            @(negedge clk);
            hi++;
        end
        chk("t1_stb_high", hi, 8);
        wait_busy(1'b0, 2000, "f1_end");
        repeat (2) @(negedge clk);
        build_exp(32'h76543210, 8'h00, 8'h00, 1'b1, 3'd7);
        check_frame("f1");
        chk("f1_busy_len", busy_len, 1264);
        chk("f1_done_cnt", fd_cnt, 1);

        // frame 2: blanking, dp and LEDs
        bus_q.delete();
        digits = 32'hFFFF1234;
        dots = 8'h04;
        leds = 8'hA5;
        wait_busy(1'b1, 2100, "f2_start");
        wait_busy(1'b0, 2000, "f2_end");
        repeat (2) @(negedge clk);
        build_exp(32'hFFFF1234, 8'h04, 8'hA5, 1'b1, 3'd7);
        check_frame("f2");
        if (rise_t.size() >= 2) chk("latch_period_12", rise_t[1] - rise_t[0], 2000);

        // frames 3/4: input change in the middle of T2
        bus_q.delete();
        digits = 32'h00000000;
        dots = 8'h00;
        leds = 8'h00;
        wait_busy(1'b1, 2100, "f3_start");
        repeat (300) @(negedge clk);
        digits = 32'h99999999;
        wait_busy(1'b0, 2000, "f3_end");
        repeat (2) @(negedge clk);
        build_exp(32'h00000000, 8'h00, 8'h00, 1'b1, 3'd7);
        check_frame("f3");
        bus_q.delete();
        wait_busy(1'b1, 2100, "f4_start");
        wait_busy(1'b0, 2000, "f4_end");
        repeat (2) @(negedge clk);
        build_exp(32'h99999999, 8'h00, 8'h00, 1'b1, 3'd7);
        check_frame("f4");
        if (rise_t.size() >= 4) chk("latch_period_34", rise_t[3] - rise_t[2], 2000);

        // frame 5 aborted by reset in T2 byte 7; frame 6 restarts with display off, level 3
        disp_on = 1'b0;
        bright = 3'd3;
        wait_busy(1'b1, 2100, "f5_start");
        repeat (552) @(negedge clk);
        rs = 1'b0;
        @(negedge clk);
        chk("mid_rst_out", {29'b0, tm_stb, tm_clk, busy}, 32'b110);
        rs = 1'b1;
        bus_q.delete();
        wait_busy(1'b1, 10, "f6_start");
        wait_busy(1'b0, 2000, "f6_end");
        repeat (2) @(negedge clk);
        if (bus_q.size() > 0) chk("post_rst_first", {24'b0, bus_q[0]}, 32'h40);
        build_exp(32'h99999999, 8'h00, 8'h00, 1'b0, 3'd3);
        check_frame("f6");

        chk("dio_stable", viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
